// File: rtl/stage_pkg.sv
// stage_pkg: stage encoding and shared constants for the instruction stage sequencer.
package stage_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALTED    = 3'd6,
        ERROR     = 3'd7
    } stage_t;
    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int WDOG_W          = 8;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts cycles spent waiting on data memory; expires on the LIMIT-th waiting cycle.
module mem_watchdog import stage_pkg::*; #(
    parameter int LIMIT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign expired_o = en_i && cnt_q == WDOG_W'(LIMIT - 1);
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: single-clock multi-cycle stage controller producing one-hot stage strobes,
// branch resolution, memory handshake with timeout, and a retired-instruction count.
module stage_sequencer import stage_pkg::*; #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             uncondbranch,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             ir_load,
    output logic             rf_read,
    output logic             alu_en,
    output logic             mem_req,
    output logic             rf_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             error
);
    stage_t           state_q, state_d;
    logic             need_mem_q, need_mem_d, need_wb_q, need_wb_d;
    logic             is_ub_q, is_ub_d, is_cb_q, is_cb_d, take_q, take_d, halt_q, halt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             in_mem, in_instr, expired, take_now, final_stage;

    assign in_mem      = state_q == MEMORY;
    assign in_instr    = state_q inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK};
    assign take_now    = is_ub_q | (is_cb_q & alu_zero);
    assign final_stage = (state_q == EXECUTE && !need_mem_q && !need_wb_q) ||
                         (in_mem && mem_ack && !need_wb_q) || state_q == WRITEBACK;

    mem_watchdog #(.LIMIT(MEM_TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_ni   (reset),
        .clr_i    (!in_mem || mem_ack),
        .en_i     (in_mem),
        .expired_o(expired)
    );

    always_comb begin
        state_d    = state_q;
        need_mem_d = need_mem_q;
        need_wb_d  = need_wb_q;
        is_ub_d    = is_ub_q;
        is_cb_d    = is_cb_q;
        take_d     = take_q;
        retired_d  = final_stage ? retired_q + 1'b1 : retired_q;
        // A halt request seen mid-instruction is held until the instruction boundary.
        halt_d     = final_stage ? 1'b0 : halt_q | (halt_req & in_instr);
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = DECODE;
            DECODE: begin
                need_mem_d = mem_read | mem_write;
                need_wb_d  = reg_write & ~mem_write;
                is_ub_d    = uncondbranch;
                is_cb_d    = branch;
                state_d    = EXECUTE;
            end
            EXECUTE: begin
                take_d  = take_now;
                state_d = need_mem_q ? MEMORY : need_wb_q ? WRITEBACK : EXECUTE;
            end
            MEMORY:  state_d = mem_ack ? (need_wb_q ? WRITEBACK : MEMORY) : expired ? ERROR : MEMORY;
            HALTED:  state_d = (start && !halt_req) ? FETCH : HALTED;
            default: state_d = state_q;
        endcase
        if (final_stage) state_d = (halt_req || halt_q) ? HALTED : FETCH;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q    <= IDLE;
            need_mem_q <= 1'b0;
            need_wb_q  <= 1'b0;
            is_ub_q    <= 1'b0;
            is_cb_q    <= 1'b0;
            take_q     <= 1'b0;
            halt_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            need_mem_q <= need_mem_d;
            need_wb_q  <= need_wb_d;
            is_ub_q    <= is_ub_d;
            is_cb_q    <= is_cb_d;
            take_q     <= take_d;
            halt_q     <= halt_d;
            retired_q  <= retired_d;
        end

    assign ir_load  = state_q == FETCH;
    assign rf_read  = state_q == DECODE;
    assign alu_en   = state_q == EXECUTE;
    assign mem_req  = in_mem;
    assign rf_write = state_q == WRITEBACK;
    assign pc_write = final_stage;
    assign pc_src   = final_stage && (state_q == EXECUTE ? take_now : take_q);
    assign state    = state_q;
    assign retired  = retired_q;
    assign halted   = state_q == HALTED;
    assign error    = state_q == ERROR;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed and randomized instruction streams checked against a per-instruction stage-path model.
module tb_stage_sequencer;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset, start, halt_req, uncondbranch, branch, mem_read, mem_write, reg_write, alu_zero, mem_ack;
    logic        ir_load, rf_read, alu_en, mem_req, rf_write, pc_write, pc_src, halted, error;
    logic [2:0]  state;
    logic [31:0] retired;
    int          checks = 0;
    int          errors = 0;
    int          exp_retired = 0;

    stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .uncondbranch(uncondbranch), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_zero(alu_zero), .mem_ack(mem_ack),
        .ir_load(ir_load), .rf_read(rf_read), .alu_en(alu_en), .mem_req(mem_req), .rf_write(rf_write),
        .pc_write(pc_write), .pc_src(pc_src), .state(state), .retired(retired), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ctl();
        uncondbranch = 1'($urandom());
        branch       = 1'($urandom());
        mem_read     = 1'($urandom());
        mem_write    = 1'($urandom());
        reg_write    = 1'($urandom());
        alu_zero     = 1'($urandom());
    endtask

    // Expected path is derived from the instruction class: F, D, E, [M x (wait+1)], [W].
    task automatic run_instr(input bit ub, cb, mr, mw, rw, az, input int ack_dly, input int halt_at);
        int  seq[$];
        int  mcnt;
        bit  take;
        take = ub | (cb & az);
        seq  = {1, 2, 3};
        if (mr | mw) for (int i = 0; i <= ack_dly; i++) seq.push_back(4);
        if (rw & ~mw) seq.push_back(5);
        mcnt = 0;
        for (int c = 0; c < seq.size(); c++) begin
            @(negedge clk);
            rand_ctl();
            start   = 1'($urandom());
            mem_ack = 1'($urandom());
            if (c == 1) begin
                uncondbranch = ub; branch = cb; mem_read = mr; mem_write = mw; reg_write = rw;
            end
            if (c == 2) alu_zero = az;
            if (seq[c] == 4) begin
                mem_ack = (mcnt == ack_dly);
                mcnt++;
            end
            halt_req = (c == halt_at);
            #1;
            if (c == 0) chk("retired", retired, 32'(exp_retired));
            chk("state", 32'(state), 32'(seq[c]));
            chk("ir_load", 32'(ir_load), 32'(seq[c] == 1));
            chk("rf_read", 32'(rf_read), 32'(seq[c] == 2));
            chk("alu_en", 32'(alu_en), 32'(seq[c] == 3));
            chk("mem_req", 32'(mem_req), 32'(seq[c] == 4));
            chk("rf_write", 32'(rf_write), 32'(seq[c] == 5));
            chk("pc_write", 32'(pc_write), 32'(c == seq.size() - 1));
            chk("pc_src", 32'(pc_src), 32'((c == seq.size() - 1) && take));
        end
        exp_retired++;
        if (halt_at >= 0) begin
            @(negedge clk);
            halt_req = 1'b0; start = 1'b0; mem_ack = 1'($urandom());
            #1;
            chk("halt_state", 32'(state), 32'd6);
            chk("halted", 32'(halted), 32'd1);
            chk("halt_retired", retired, 32'(exp_retired));
            @(negedge clk);
            start = 1'b1;
            #1;
            chk("halt_hold", 32'(state), 32'd6);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
        uncondbranch = 1'b0; branch = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; alu_zero = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_strobes", 32'({ir_load, rf_read, alu_en, mem_req, rf_write, pc_write, halted, error}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("idle_wait", 32'(state), 32'd0);
        @(negedge clk);
        start = 1'b1;
        #1 chk("idle_start", 32'(state), 32'd0);
        run_instr(0, 0, 1, 0, 1, 0, 0, -1);  // LDUR
        run_instr(0, 0, 0, 0, 1, 0, 0, -1);  // ADD
        run_instr(0, 0, 0, 0, 1, 1, 0, -1);  // SUB
        run_instr(0, 0, 0, 1, 0, 0, 3, -1);  // STUR, ack on the last allowed cycle
        run_instr(0, 1, 0, 0, 0, 1, 0, -1);  // CBZ taken
        run_instr(0, 1, 0, 0, 0, 0, 0, -1);  // CBZ not taken
        run_instr(1, 0, 0, 0, 0, 0, 0, -1);  // B
        run_instr(1, 1, 0, 0, 0, 0, 0, -1);  // both branch flags
        run_instr(0, 0, 1, 1, 1, 0, 1, -1);  // read+write acts as a store
        run_instr(0, 0, 0, 0, 1, 0, 0, 1);   // ADD with halt during DECODE
        for (int n = 0; n < 40; n++)
            run_instr(1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                      1'($urandom()), int'($urandom_range(0, TMO - 1)),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1);
        // Reset in the middle of a memory wait discards the instruction.
        @(negedge clk); rand_ctl(); halt_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk); mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        @(negedge clk); rand_ctl();
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("mid_mem_state", 32'(state), 32'd4);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_retired", retired, 32'd0);
        chk("async_rst_memreq", 32'(mem_req), 32'd0);
        chk("async_rst_pcwrite", 32'(pc_write), 32'd0);
        exp_retired = 0;
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        chk("restart_irload", 32'(ir_load), 32'd1);
        chk("restart_state", 32'(state), 32'd1);
        // Store that never sees an ack must end in ERROR after TMO memory cycles.
        @(negedge clk); uncondbranch = 1'b0; branch = 1'b0; mem_read = 1'b0; mem_write = 1'b1; reg_write = 1'b0;
        #1 chk("tmo_decode", 32'(state), 32'd2);
        @(negedge clk); #1 chk("tmo_exec", 32'(state), 32'd3);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk); mem_ack = 1'b0; #1;
            chk("tmo_mem_state", 32'(state), 32'd4);
            chk("tmo_mem_req", 32'(mem_req), 32'd1);
            chk("tmo_pc_write", 32'(pc_write), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ack = 1'b1; start = 1'b1; #1;
            chk("err_state", 32'(state), 32'd7);
            chk("err_flag", 32'(error), 32'd1);
            chk("err_mem_req", 32'(mem_req), 32'd0);
            chk("err_pc_write", 32'(pc_write), 32'd0);
            chk("err_retired", retired, 32'(exp_retired));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
